// File: rtl/i3c_scl_gen.sv
// i3c_scl_gen: SCL phase generator with push-pull/open-drain timing, stretch detection and bit handshake
module i3c_scl_gen #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [CNT_W-1:0] cfg_pp_low,
  input  logic [CNT_W-1:0] cfg_pp_high,
  input  logic [CNT_W-1:0] cfg_od_low,
  input  logic [CNT_W-1:0] cfg_od_high,
  input  logic             bit_od,
  input  logic             bit_req,
  output logic             bit_ack,
  output logic             bit_done,
  input  logic             abort,
  input  logic             scl_in,
  output logic             scl_o,
  output logic             scl_oe,
  output logic             fall_stb,
  output logic             rise_stb,
  output logic             stretched
);
  typedef enum logic [1:0] {IDLE, LOW, HWAIT, HIGH} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, hi_q, hi_n;
  logic od_q, od_n, first, first_n, s1, s2, last, accept;

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  assign last   = cnt == '0;
  assign accept = !abort && bit_req && (st == IDLE || (st == HIGH && last));

  // Two-flop synchronizer for the SCL pad sense, idling high like the bus
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= scl_in;
      s2 <= s1;
    end
  end

  // State, phase counter, captured bit mode and first-cycle-of-phase flag
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st    <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      od_q  <= 1'b0;
      first <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      od_q  <= od_n;
      first <= first_n;
    end
  end

  // Next-state: phases end at count 0; acceptance and abort override the per-state step
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    hi_n    = hi_q;
    od_n    = od_q;
    first_n = 1'b0;
    case (st)
      LOW: begin
        cnt_n = last ? cnt : cnt - CNT_W'(1);
        if (last) begin
          st_n    = od_q ? HWAIT : HIGH;
          cnt_n   = od_q ? cnt : hi_q;
          first_n = !od_q;
        end
      end
      HWAIT: begin
        st_n    = s2 ? HIGH : HWAIT;
        cnt_n   = s2 ? hi_q : cnt;
        first_n = s2;
      end
      HIGH: begin
        st_n  = last ? IDLE : HIGH;
        cnt_n = last ? cnt : cnt - CNT_W'(1);
      end
      default: ;
    endcase
    if (accept) begin
      st_n    = LOW;
      cnt_n   = len_m1(bit_od ? cfg_od_low : cfg_pp_low);
      hi_n    = len_m1(bit_od ? cfg_od_high : cfg_pp_high);
      od_n    = bit_od;
      first_n = 1'b1;
    end
    if (abort) begin
      st_n    = IDLE;
      cnt_n   = '0;
      first_n = 1'b0;
    end
  end

  assign scl_o     = st != LOW;
  assign scl_oe    = st == LOW || (st == HIGH && !od_q);
  assign fall_stb  = st == LOW && first;
  assign bit_ack   = fall_stb;
  assign rise_stb  = st == HIGH && first;
  assign stretched = st == HWAIT;
  assign bit_done  = !abort && st == HIGH && last;
endmodule

// File: tb/tb_i3c_scl_gen.sv
// tb_i3c_scl_gen: per-cycle vector tables with a scoreboard queue for i3c_scl_gen
module tb_i3c_scl_gen;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic [7:0] cfg_pp_low = '0, cfg_pp_high = '0, cfg_od_low = '0, cfg_od_high = '0;
  logic bit_od = 1'b0, bit_req = 1'b0, abort = 1'b0, scl_in = 1'b1;
  logic bit_ack, bit_done, scl_o, scl_oe, fall_stb, rise_stb, stretched;
  logic [6:0] obs;

  i3c_scl_gen #(.CNT_W(8)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cfg_pp_low(cfg_pp_low), .cfg_pp_high(cfg_pp_high),
    .cfg_od_low(cfg_od_low), .cfg_od_high(cfg_od_high),
    .bit_od(bit_od), .bit_req(bit_req), .bit_ack(bit_ack), .bit_done(bit_done),
    .abort(abort), .scl_in(scl_in), .scl_o(scl_o), .scl_oe(scl_oe),
    .fall_stb(fall_stb), .rise_stb(rise_stb), .stretched(stretched)
  );

  always #5 CLK = ~CLK;

  // {scl_o, scl_oe, fall_stb, rise_stb, bit_ack, bit_done, stretched}
  assign obs = {scl_o, scl_oe, fall_stb, rise_stb, bit_ack, bit_done, stretched};

  localparam logic [6:0] IDL  = 7'b1000000;
  localparam logic [6:0] LO   = 7'b0100000;
  localparam logic [6:0] LF   = 7'b0110100;
  localparam logic [6:0] PH   = 7'b1100000;
  localparam logic [6:0] PHR  = 7'b1101000;
  localparam logic [6:0] PHD  = 7'b1100010;
  localparam logic [6:0] PHRD = 7'b1101010;
  localparam logic [6:0] OW   = 7'b1000001;
  localparam logic [6:0] OH   = 7'b1000000;
  localparam logic [6:0] OHR  = 7'b1001000;
  localparam logic [6:0] OHD  = 7'b1000010;

  typedef struct {
    string n;
    logic req, od, abt, sin;
    logic [31:0] cfg;
    logic [6:0] e;
  } row_t;
  typedef struct {
    string n;
    logic [6:0] e;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  logic [31:0] cur_cfg;
  int tests = 0, fails = 0;

  function automatic void add(string n, logic req, logic od, logic abt, logic sin, logic [6:0] e);
    rows.push_back('{n, req, od, abt, sin, cur_cfg, e});
  endfunction

  task automatic check(string n, logic [6:0] act, logic [6:0] e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", n, act, e);
    end
  endtask

  task automatic run();
    exp_t x;
    foreach (rows[i]) begin
      @(posedge CLK);
      #1;
      bit_req = rows[i].req;
      bit_od  = rows[i].od;
      abort   = rows[i].abt;
      scl_in  = rows[i].sin;
      {cfg_pp_low, cfg_pp_high, cfg_od_low, cfg_od_high} = rows[i].cfg;
      exp_q.push_back('{$sformatf("%s[%0d]", rows[i].n, i), rows[i].e});
      @(negedge CLK);
      x = exp_q.pop_front();
      check(x.n, obs, x.e);
    end
    rows.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset", obs, IDL);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;

    cur_cfg = {8'd3, 8'd2, 8'd0, 8'd0};
    add("pp", 1, 0, 0, 1, IDL);
    cur_cfg = {8'd7, 8'd7, 8'd0, 8'd0};
    add("pp", 0, 0, 0, 1, LF);
    add("pp", 0, 0, 0, 1, LO);
    add("pp", 0, 0, 0, 1, LO);
    add("pp", 0, 0, 0, 1, PHR);
    add("pp", 0, 0, 0, 1, PHD);
    add("pp", 0, 0, 0, 1, IDL);
    add("pp", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = {8'd1, 8'd1, 8'd0, 8'd0};
    add("b2b", 1, 0, 0, 1, IDL);
    for (int b = 0; b < 4; b++) begin
      add("b2b", b < 3, 0, 0, 1, LF);
      add("b2b", b < 3, 0, 0, 1, PHRD);
    end
    add("b2b", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = '0;
    add("zero", 1, 0, 0, 1, IDL);
    add("zero", 1, 0, 0, 1, LF);
    add("zero", 1, 0, 0, 1, PHRD);
    add("zero", 0, 0, 0, 1, LF);
    add("zero", 0, 0, 0, 1, PHRD);
    add("zero", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = {8'd0, 8'd0, 8'd4, 8'd4};
    add("od", 1, 1, 0, 1, IDL);
    cur_cfg = {8'd9, 8'd9, 8'd1, 8'd1};
    add("od", 0, 0, 0, 0, LF);
    for (int k = 0; k < 3; k++) add("od", 0, 0, 0, 0, LO);
    for (int k = 0; k < 10; k++) add("od", 0, 0, 0, 0, OW);
    for (int k = 0; k < 3; k++) add("od", 0, 0, 0, 1, OW);
    add("od", 0, 0, 0, 1, OHR);
    add("od", 0, 0, 0, 0, OH);
    add("od", 0, 0, 0, 0, OH);
    add("od", 0, 0, 0, 1, OHD);
    add("od", 0, 0, 0, 1, IDL);
    add("od", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = {8'd10, 8'd2, 8'd0, 8'd0};
    add("abort_low", 1, 0, 0, 1, IDL);
    add("abort_low", 1, 0, 0, 1, LF);
    add("abort_low", 1, 0, 0, 1, LO);
    add("abort_low", 1, 0, 1, 1, LO);
    add("abort_low", 0, 0, 0, 1, IDL);
    add("abort_low", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = {8'd1, 8'd2, 8'd0, 8'd0};
    add("abort_high", 1, 0, 0, 1, IDL);
    add("abort_high", 1, 0, 0, 1, LF);
    add("abort_high", 1, 0, 0, 1, PHR);
    add("abort_high", 1, 0, 1, 1, PH);
    add("abort_high", 0, 0, 0, 1, IDL);
    add("abort_high", 0, 0, 0, 1, IDL);
    run();

    cur_cfg = {8'd2, 8'd5, 8'd0, 8'd0};
    add("pre_rst", 1, 0, 0, 1, IDL);
    add("pre_rst", 0, 0, 0, 1, LF);
    add("pre_rst", 0, 0, 0, 1, LO);
    add("pre_rst", 0, 0, 0, 1, PHR);
    run();
    #1 RSTn = 1'b0;
    #1 check("rst_async", obs, IDL);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_hold", obs, IDL);
    RSTn = 1'b1;

    add("post_rst", 1, 0, 0, 1, IDL);
    add("post_rst", 0, 0, 0, 1, LF);
    add("post_rst", 0, 0, 0, 1, LO);
    add("post_rst", 0, 0, 0, 1, PHR);
    for (int k = 0; k < 3; k++) add("post_rst", 0, 0, 0, 1, PH);
    add("post_rst", 0, 0, 0, 1, PHD);
    add("post_rst", 0, 0, 0, 1, IDL);
    run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
